// File: rtl/uart_rx_os_pkg.sv
// uart_rx_os_pkg: receiver FSM state type and oversample tick divider helper
package uart_rx_os_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  function automatic int div_calc(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction
endpackage

// File: rtl/os_tick_gen.sv
// os_tick_gen: one-clock s_tick every clk_freq/(baud_rate*oversample) clocks
module os_tick_gen
  import uart_rx_os_pkg::*;
#(
  parameter int clk_freq = 50000000,
  parameter int baud_rate = 9600,
  parameter int oversample = 16
) (
  input logic clk,
  input logic rst,
  output logic s_tick
);
  localparam int div = div_calc(clk_freq, baud_rate, oversample);
  localparam int cw = $clog2(div + 1);
  logic [cw-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      s_tick <= 1'b0;
    end else begin
      cnt <= cnt == cw'(div - 1) ? '0 : cnt + 1'b1;
      s_tick <= cnt == cw'(div - 1);
    end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling 8N1 UART receiver with 2-of-3 voting, framing/overrun flags, valid/ready output
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int clk_freq = 50000000,
  parameter int baud_rate = 9600,
  parameter int oversample = 16,
  parameter int data_bits = 8
) (
  input logic clk,
  input logic rst,
  input logic rx_in,
  output logic [data_bits-1:0] rx_data,
  output logic rx_valid,
  input logic rx_ready,
  output logic frame_err,
  output logic overrun,
  output logic rx_busy
);
  localparam int m = oversample / 2;
  localparam int pw = $clog2(oversample);
  logic s_tick, sync1, rx_s, armed, smp1, smp2, vote, vote_pt, end_pt, dlv;
  logic [pw-1:0] phase;
  logic [3:0] bit_cnt;
  logic [data_bits-1:0] shreg;
  state_t state, state_n;
  os_tick_gen #(.clk_freq(clk_freq), .baud_rate(baud_rate), .oversample(oversample)) u_tick (
    .clk(clk),
    .rst(rst),
    .s_tick(s_tick)
  );
  assign vote = (smp1 & smp2) | (smp1 & rx_s) | (smp2 & rx_s);
  assign vote_pt = s_tick && phase == pw'(m + 1);
  assign end_pt = s_tick && phase == pw'(oversample - 1);
  assign rx_busy = state != IDLE;
  always_comb
    state_n = state == IDLE  ? (s_tick && !rx_s && armed ? START : IDLE) :
              state == START ? (vote_pt && vote ? IDLE : end_pt ? DATA : START) :
              state == DATA  ? (end_pt && bit_cnt == 4'(data_bits - 1) ? STOP : DATA) :
              (vote_pt ? IDLE : STOP);
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= 1'b1;
      rx_s <= 1'b1;
      armed <= 1'b1;
      smp1 <= 1'b1;
      smp2 <= 1'b1;
      phase <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      dlv <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
    end else begin
      sync1 <= rx_in;
      rx_s <= sync1;
      dlv <= state == STOP && vote_pt && vote;
      frame_err <= state == STOP && vote_pt && !vote;
      overrun <= dlv && rx_valid && !rx_ready;
      if (state == STOP && vote_pt && !vote) armed <= 1'b0;
      else if (s_tick && rx_s) armed <= 1'b1;
      if (s_tick) begin
        phase <= state == IDLE || phase == pw'(oversample - 1) ? '0 : phase + 1'b1;
        smp1 <= phase == pw'(m - 1) ? rx_s : smp1;
        smp2 <= phase == pw'(m) ? rx_s : smp2;
      end
      if (end_pt) bit_cnt <= state == DATA ? bit_cnt + 1'b1 : '0;
      if (vote_pt && state == DATA) shreg <= {vote, shreg[data_bits-1:1]};
      if (dlv && (!rx_valid || rx_ready)) begin
        rx_data <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_ready) rx_valid <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed self-checking bench for uart_rx_os at a scaled clock (10 clocks per s_tick)
module tb_uart_rx_os;
  localparam int bt = 160;
  logic clk = 1'b0, rst = 1'b1, rx_in = 1'b1, rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, rx_busy;
  int vectors = 0, miscompares = 0;
  int vcnt = 0, vhigh = 0, fecnt = 0, ovcnt = 0, brise = 0, coinc = 0;
  int v0, h0, f0, o0, b0;
  logic [7:0] got [0:63];
  logic pv = 1'b0, pb = 1'b0;
  uart_rx_os #(.clk_freq(1536000), .baud_rate(9600), .oversample(16), .data_bits(8)) dut (
    .clk(clk),
    .rst(rst),
    .rx_in(rx_in),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun(overrun),
    .rx_busy(rx_busy)
  );
  always #10 clk = ~clk;
  always @(negedge clk) begin
    if (rx_valid && !pv) begin
      got[vcnt[5:0]] <= rx_data;
      vcnt <= vcnt + 1;
      if (frame_err || overrun) coinc <= coinc + 1;
    end
    if (rx_valid) vhigh <= vhigh + 1;
    if (frame_err) fecnt <= fecnt + 1;
    if (overrun) ovcnt <= ovcnt + 1;
    if (rx_busy && !pb) brise <= brise + 1;
    pv <= rx_valid;
    pb <= rx_busy;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic snap;
    v0 = vcnt;
    h0 = vhigh;
    f0 = fecnt;
    o0 = ovcnt;
    b0 = brise;
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input int w);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = f[i];
      idle(w);
    end
    rx_in = 1'b1;
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    idle(5);
    check("rst_data", rx_data, 0);
    check("rst_valid", rx_valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", rx_busy, 0);
    rst = 1'b0;
    idle(2 * bt);
    snap;
    send(8'hA5, 1'b1, bt);
    idle(bt);
    check("t1_count", vcnt - v0, 1);
    check("t1_data", got[v0], 8'hA5);
    check("t1_width", vhigh - h0, 1);
    check("t1_ferr", fecnt - f0, 0);
    check("t1_ovr", ovcnt - o0, 0);
    check("t1_busy", rx_busy, 0);
    snap;
    rx_in = 1'b0;
    idle(30);
    rx_in = 1'b1;
    idle(2 * bt);
    check("t2_busy_pulse", brise - b0, 1);
    check("t2_no_valid", vcnt - v0, 0);
    check("t2_idle", rx_busy, 0);
    snap;
    send(8'h3C, 1'b0, bt);
    idle(2 * bt);
    send(8'h55, 1'b1, bt);
    idle(bt);
    check("t3_ferr", fecnt - f0, 1);
    check("t3_count", vcnt - v0, 1);
    check("t3_data", got[v0], 8'h55);
    check("t3_ovr", ovcnt - o0, 0);
    rx_ready = 1'b0;
    snap;
    send(8'h11, 1'b1, bt);
    send(8'h22, 1'b1, bt);
    idle(bt);
    check("t4_valid_held", rx_valid, 1);
    check("t4_data_kept", rx_data, 8'h11);
    check("t4_ovr", ovcnt - o0, 1);
    check("t4_count", vcnt - v0, 1);
    rx_ready = 1'b1;
    idle(1);
    check("t4_accept", rx_valid, 0);
    rx_ready = 1'b0;
    send(8'h77, 1'b1, bt);
    idle(bt);
    check("t5_pre_valid", rx_valid, 1);
    rx_in = 1'b0;
    idle(bt);
    rx_in = 1'b1;
    idle(bt);
    rx_in = 1'b0;
    idle(bt / 2);
    check("t5_pre_busy", rx_busy, 1);
    rst = 1'b1;
    idle(3);
    check("t5_rst_valid", rx_valid, 0);
    check("t5_rst_data", rx_data, 0);
    check("t5_rst_busy", rx_busy, 0);
    check("t5_rst_ferr", frame_err, 0);
    rx_in = 1'b1;
    idle(bt);
    rst = 1'b0;
    rx_ready = 1'b1;
    idle(bt);
    snap;
    send(8'h5A, 1'b1, bt);
    idle(bt);
    check("t5_count", vcnt - v0, 1);
    check("t5_data", got[v0], 8'h5A);
    check("t5_ferr", fecnt - f0, 0);
    snap;
    send(8'h00, 1'b1, 157);
    send(8'hFF, 1'b1, 157);
    idle(bt);
    check("t6f_count", vcnt - v0, 2);
    check("t6f_d0", got[v0], 8'h00);
    check("t6f_d1", got[v0+1], 8'hFF);
    check("t6f_err", (fecnt - f0) + (ovcnt - o0), 0);
    snap;
    send(8'h00, 1'b1, 163);
    send(8'hFF, 1'b1, 163);
    idle(bt);
    check("t6s_count", vcnt - v0, 2);
    check("t6s_d0", got[v0], 8'h00);
    check("t6s_d1", got[v0+1], 8'hFF);
    check("t6s_err", (fecnt - f0) + (ovcnt - o0), 0);
    check("no_coincide", coinc, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
